spi_slave_ctrl: RTL
===================

Name: spi_slave_ctrl

Overview:
SPI slave front end that produces the 10-bit command/data word stream consumed by the single-port RAM (din[9:8] opcode + 8-bit payload, rx_valid strobe). It returns RAM read data (dout/tx_valid) serially on MISO. The SPI bit clock is CLK itself: one MOSI bit is sampled per CLK rising edge while SS_n is low.

Parameters:
ADDR_SIZE, 8, payload/address width
FRAME_WIDTH, 10, bits per command frame (ADDR_SIZE+2)
DATA_WIDTH, 8, width of read data returned on MISO

Ports:
CLK  input  1  system/SPI clock, rising edge
rst_n  input  1  asynchronous active-low reset
SS_n  input  1  slave select, active low; high aborts any frame
MOSI  input  1  serial data in, MSB first
MISO  output  1  serial data out, MSB first
rx_data  output  FRAME_WIDTH  assembled frame {opcode[1:0], payload}
rx_valid  output  1  one-cycle strobe, rx_data valid
tx_data  input  DATA_WIDTH  read data from RAM
tx_valid  input  1  tx_data valid strobe from RAM

Behaviour:
- Reset (async, rst_n low): state=IDLE, MISO=0, rx_data=0, rx_valid=0, bit counter=0, rd_addr_seen=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n sampled low -> CHK_CMD next cycle; else stay.
- CHK_CMD: MOSI is frame bit 9; shifted in, counter=1. MOSI=0 -> WRITE; MOSI=1 and rd_addr_seen=0 -> READ_ADD; MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE/READ_ADD/READ_DATA: shift one MOSI bit per cycle into rx_data LSB, MSB first, until counter=FRAME_WIDTH. rx_data updates only when the frame completes (internal shift register); rx_valid=1 exactly one cycle, the cycle after the 10th bit is sampled.
- Path is chosen by bit 9 and rd_addr_seen only; bit 8 is passed through unchanged in rx_data.
- READ_ADD completion sets rd_addr_seen=1. READ_DATA frame completion clears rd_addr_seen=0. WRITE does not touch it.
- WRITE/READ_ADD after completion: hold, ignore further MOSI until SS_n high.
- READ_DATA after rx_valid: wait for tx_valid (no timeout). On tx_valid, tx_data is loaded into the output shifter; the next 8 cycles drive MISO = tx_data[7] .. tx_data[0], one bit per cycle. MISO=0 afterwards and whenever not shifting. A tx_valid seen outside this wait window is ignored.
- SS_n sampled high in any non-IDLE state -> IDLE next cycle; partial frame discarded (no rx_valid, rd_addr_seen unchanged, MISO=0). SS_n high on the cycle the 10th bit would be sampled also aborts.
- rx_valid and SS_n rise in the same cycle: strobe still issued (frame was already complete).
- Counter wraps only via reset to 0 on entry to IDLE; never exceeds FRAME_WIDTH.

Optional Feature:
SPI_FRAME_ERR_EN. When defined: extra output frame_err (1 bit, reset 0) pulses one cycle on (a) SS_n abort mid-frame or mid-MISO-shift, or (b) a completed frame whose bit 8 disagrees with the chosen path (WRITE expects 0 or 1; READ_ADD expects 0; READ_DATA expects 1). Case (b) still issues rx_valid. When not defined: no port, no logic, and the behaviour is otherwise identical.

Decomposition:
- spi_pkg: state enum, opcode constants (OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11), FRAME_WIDTH default.
- One sub-module: spi_tx_shifter (load on strobe, DATA_WIDTH-cycle MSB-first serializer, busy flag).

Test Plan:
- Write addr: SS_n low, MOSI=00_0000_0101 -> rx_data=10'h005, single rx_valid pulse 1 cycle after 10th bit; MISO stays 0.
- Write data: MOSI=01_1010_1010 -> rx_data=10'h1AA, rx_valid once; rd_addr_seen unchanged.
- Read sequence: frame 10_0000_0101 -> READ_ADD, rx_data=10'h205; next frame 11_xxxx_xxxx -> READ_DATA, rx_valid; RAM tx_valid with tx_data=8'hC3 -> MISO 1,1,0,0,0,0,1,1 over next 8 cycles, then 0.
- Abort: SS_n high after 5 bits of a write frame -> IDLE, no rx_valid, next full frame decodes correctly.
- Read-data without prior read-addr: frame 11_0000_0000 with rd_addr_seen=0 -> routed to READ_ADD, rx_data=10'h300, rd_addr_seen=1, no MISO shift.
- Reset mid-MISO shift (rst_n low after 3 bits) -> MISO=0, state IDLE, rd_addr_seen=0 immediately (asynchronously).

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
// Optional macro SPI_FRAME_ERR_EN adds frame error checking.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int FRAME_W = 10;

  // bit 8 a completed frame must carry for its chosen path
  function automatic logic bit8_ok(
    spi_state_e s,
    logic       b8
  );
    logic ok;
    ok = 1'b1;
    if (s == READ_ADD) ok = (b8 == OP_RD_ADDR[0]);
    if (s == READ_DATA) ok = (b8 == OP_RD_DATA[0]);
    return ok;
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// MSB-first serializer for RAM read data onto MISO.
// Default build only; no optional feature here.
module spi_tx_shifter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  miso,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] buf_q;
  logic [CW-1:0]         left;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      miso  <= 1'b0;
      busy  <= 1'b0;
      buf_q <= '0;
      left  <= '0;
    end else if (clear) begin
      miso  <= 1'b0;
      busy  <= 1'b0;
      buf_q <= '0;
      left  <= '0;
    end else if (load) begin
      miso  <= data[DATA_WIDTH-1];
      busy  <= 1'b1;
      buf_q <= {data[DATA_WIDTH-2:0], 1'b0};
      left  <= CW'(DATA_WIDTH - 1);
    end else if (left != '0) begin
      miso  <= buf_q[DATA_WIDTH-1];
      buf_q <= {buf_q[DATA_WIDTH-2:0], 1'b0};
      left  <= left - CW'(1);
    end else begin
      miso <= 1'b0;
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave: MOSI frames to RAM command words, read data to MISO.
// Define SPI_FRAME_ERR_EN to add the frame_err pulse output.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE   = FRAME_W - 2,
  parameter int FRAME_WIDTH = ADDR_SIZE + 2,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic                   SS_n,
  input  logic                   MOSI,
  output logic                   MISO,
  output logic [FRAME_WIDTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic [DATA_WIDTH-1:0]  tx_data,
  input  logic                   tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                   frame_err
`endif
);

  localparam int CW = $clog2(FRAME_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_WIDTH);

  spi_state_e state, state_nxt;

  logic [CW-1:0]          cnt;
  logic [FRAME_WIDTH-2:0] sr;
  logic                   rd_addr_seen;
  logic                   tx_used;
  logic                   tx_busy;
  logic                   full;
  logic                   shift;
  logic                   done;
  logic                   load;
  logic                   abort;

  assign full = (cnt == CNT_FULL);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!SS_n) state_nxt = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else begin
          shift = 1'b1;
          if (!MOSI)             state_nxt = WRITE;
          else if (!rd_addr_seen) state_nxt = READ_ADD;
          else                    state_nxt = READ_DATA;
        end
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if (!full) begin
          shift = 1'b1;
          done  = (cnt == CNT_FULL - CW'(1));
        end else if (state == READ_DATA) begin
          load = tx_valid && !tx_used && !tx_busy;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      sr           <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_used      <= 1'b0;
    end else begin
      rx_valid <= done;
      if (state == IDLE || abort) begin
        cnt     <= '0;
        tx_used <= 1'b0;
      end else if (shift) begin
        cnt <= cnt + CW'(1);
        sr  <= {sr[FRAME_WIDTH-3:0], MOSI};
      end
      if (load) tx_used <= 1'b1;
      if (done) begin
        rx_data <= {sr, MOSI};
        if (state == READ_ADD)  rd_addr_seen <= 1'b1;
        if (state == READ_DATA) rd_addr_seen <= 1'b0;
      end
    end
  end

  spi_tx_shifter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tx (
    .CLK  (CLK),
    .rst_n(rst_n),
    .load (load),
    .clear(abort),
    .data (tx_data),
    .miso (MISO),
    .busy (tx_busy)
  );

`ifdef SPI_FRAME_ERR_EN
  logic err_abort;
  logic err_b8;

  assign err_abort = abort &&
    ((state != CHK_CMD && !full) || tx_busy);
  assign err_b8 = done &&
    !bit8_ok(state, sr[FRAME_WIDTH-3]);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= err_abort || err_b8;
  end
`endif

endmodule
